// File: rtl/seg_sched_pkg.sv
// Shared types and constants for the two-digit display scheduler.
package seg_sched_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_t;

    typedef enum logic {
        GNT_A,
        GNT_B
    } grant_t;

endpackage

// File: rtl/seg_rr_arb2.sv
// Two-way round-robin arbiter, purely combinational.
// req_i[0] is requester A, req_i[1] is requester B. On a tie the requester
// opposite last_grant_i wins; a lone requester always wins. When nothing is
// requested the grant value is meaningless and the caller must qualify it.
module seg_rr_arb2
    import seg_sched_pkg::*;
(
    input  logic [1:0] req_i,
    input  grant_t     last_grant_i,
    output grant_t     grant_o
);

    // Pick the winner from the request pattern and the previous winner.
    always_comb begin
        grant_o = GNT_A;
        case (req_i)
            2'b01:   grant_o = GNT_A;
            2'b10:   grant_o = GNT_B;
            2'b11:   grant_o = (last_grant_i == GNT_A) ? GNT_B : GNT_A;
            default: grant_o = GNT_A;
        endcase
    end

endmodule

// File: rtl/seg_digit_sched.sv
// Two-digit display scheduler: arbitrates requesters A and B round-robin,
// shifts each accepted digit in (s0 -> s1, new -> s0) and then holds the
// display for HOLD_CYCLES cycles before accepting the next digit.
//
// Optional feature macro: SEG_SCHED_DUP_FILTER_EN
//   When defined, a granted digit equal to the current s0 is accepted
//   (handshake completes, last grant updates) but the display is left
//   untouched and no hold is started.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | ready to accept one digit from the arbitrated requester
//   S_HOLD | display frozen; counting down the minimum hold time
module seg_digit_sched
    import seg_sched_pkg::*;
#(
    parameter  int HOLD_CYCLES = 2_400_000,
    localparam int CW          = $clog2(HOLD_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               a_valid,
    input  logic [DIGIT_W-1:0] a_digit,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic [DIGIT_W-1:0] b_digit,
    output logic               b_ready,
    output logic [DIGIT_W-1:0] s1,
    output logic [DIGIT_W-1:0] s0,
    output logic               busy
);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    grant_t             last_grant_q, last_grant_d;
    logic [DIGIT_W-1:0] s1_q, s1_d;
    logic [DIGIT_W-1:0] s0_q, s0_d;

    grant_t             grant;
    logic               acc_a;
    logic               acc_b;
    logic               busy_c;
    logic [DIGIT_W-1:0] digit;
    logic               do_shift;

    seg_rr_arb2 u_arb (
        .req_i        ({b_valid, a_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    // Next-state, handshake and shift decisions. Readies and busy are gated
    // with rstn so nothing is accepted while reset is being applied.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        s1_d         = s1_q;
        s0_d         = s0_q;
        acc_a        = 1'b0;
        acc_b        = 1'b0;
        busy_c       = 1'b0;
        digit        = a_digit;
        do_shift     = 1'b1;

        case (state_q)
            S_IDLE: begin
                acc_a = rstn && a_valid && (grant == GNT_A);
                acc_b = rstn && b_valid && (grant == GNT_B);
                digit = acc_b ? b_digit : a_digit;
`ifdef SEG_SCHED_DUP_FILTER_EN
                do_shift = (digit != s0_q);
`else
                do_shift = 1'b1;
`endif
                if (acc_a || acc_b) begin
                    last_grant_d = acc_b ? GNT_B : GNT_A;
                    if (do_shift) begin
                        s1_d    = s0_q;
                        s0_d    = digit;
                        cnt_d   = CW'(HOLD_CYCLES - 1);
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                busy_c = rstn;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter, arbitration history and display registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= GNT_B;
            s1_q         <= '0;
            s0_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            s1_q         <= s1_d;
            s0_q         <= s0_d;
        end
    end

    assign a_ready = acc_a;
    assign b_ready = acc_b;
    assign busy    = busy_c;
    assign s1      = s1_q;
    assign s0      = s0_q;

endmodule

// File: tb/tb_seg_digit_sched.sv
// Self-checking bench for seg_digit_sched with HOLD_CYCLES = 4.
// Reference model: display contents, last winner and the absolute cycle at
// which the scheduler next becomes free to accept.
module tb_seg_digit_sched;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       a_valid, b_valid;
    logic [3:0] a_digit, b_digit;
    logic       a_ready, b_ready, busy;
    logic [3:0] s1, s0;

    always #5 clk = ~clk;

    seg_digit_sched #(.HOLD_CYCLES(H)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .a_valid (a_valid),
        .a_digit (a_digit),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_digit (b_digit),
        .b_ready (b_ready),
        .s1      (s1),
        .s0      (s0),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int         cyc      = 0;
    logic [3:0] m_s1     = 4'h0;
    logic [3:0] m_s0     = 4'h0;
    bit         m_last_b = 1'b1;
    int         m_free   = 0;
    bit         m_acc_a, m_acc_b;
    int         m_acc_cyc;

    // Expected {a_ready, b_ready, busy, s1, s0} for the current cycle.
    function automatic logic [10:0] model_out();
        bit idle, ar, br, bz;
        idle = (rstn === 1'b1) && (cyc >= m_free);
        ar   = idle && a_valid && (!b_valid || m_last_b);
        br   = idle && b_valid && (!a_valid || !m_last_b);
        bz   = (rstn === 1'b1) && (cyc < m_free);
        return {ar, br, bz, m_s1, m_s0};
    endfunction

    // Advance the model across one rising edge.
    task automatic model_edge();
        logic [10:0] o;
        logic [3:0]  d;
        bit          dup;
        o       = model_out();
        m_acc_a = o[10];
        m_acc_b = o[9];
        if (rstn !== 1'b1) begin
            m_s1     = 4'h0;
            m_s0     = 4'h0;
            m_last_b = 1'b1;
            m_free   = 0;
        end else if (m_acc_a || m_acc_b) begin
            d         = m_acc_a ? a_digit : b_digit;
            m_last_b  = m_acc_b;
            m_acc_cyc = cyc;
            dup       = 1'b0;
`ifdef SEG_SCHED_DUP_FILTER_EN
            dup = (d == m_s0);
`endif
            if (!dup) begin
                m_s1   = m_s0;
                m_s0   = d;
                m_free = cyc + 1 + H;
            end
        end
        cyc++;
    endtask

    // One clock: update the model on the edge, then retire accepted requests.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (m_acc_a) a_valid = 1'b0;
        if (m_acc_b) b_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        rstn = 1'b0; a_valid = 1'b1; a_digit = 4'h9; b_valid = 1'b0; b_digit = 4'h0;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1; exp = model_out(); n_checks++;
            if ({a_ready, b_ready, busy, s1, s0} !== exp) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, {a_ready, b_ready, busy, s1, s0}, exp);
            end
            tick();
        end
        rstn = 1'b1; a_valid = 1'b0;
    endtask

    task automatic test_single();
        logic [10:0] exp;
        int busy_cnt = 0;
        a_valid = 1'b1; a_digit = 4'h5;
        for (int i = 0; i < H + 3; i++) begin
            #1; exp = model_out(); n_checks++;
            if ({a_ready, b_ready, busy, s1, s0} !== exp) begin
                n_fail++;
                $display("FAIL single cyc=%0d got=%h exp=%h", cyc, {a_ready, b_ready, busy, s1, s0}, exp);
            end
            if (busy === 1'b1) busy_cnt++;
            tick();
        end
        n_checks++;
        if (busy_cnt != H) begin
            n_fail++;
            $display("FAIL single_hold_len got=%0d exp=%0d", busy_cnt, H);
        end
    endtask

    task automatic test_tie();
        logic [10:0] exp;
        byte src_q[$];
        bit  a_again = 1'b0;
        rstn = 1'b0; tick(); rstn = 1'b1;
        a_valid = 1'b1; a_digit = 4'h1; b_valid = 1'b1; b_digit = 4'h2;
        for (int i = 0; i < 3 * (H + 1) + 2; i++) begin
            #1; exp = model_out(); n_checks++;
            if ({a_ready, b_ready, busy, s1, s0} !== exp) begin
                n_fail++;
                $display("FAIL tie cyc=%0d got=%h exp=%h", cyc, {a_ready, b_ready, busy, s1, s0}, exp);
            end
            tick();
            if (m_acc_a) src_q.push_back("A");
            if (m_acc_b) src_q.push_back("B");
            if (m_acc_a && !a_again) begin
                a_again = 1'b1; a_valid = 1'b1; a_digit = 4'h3;
            end
        end
        n_checks++;
        if (src_q.size() != 3 || src_q[0] != "A" || src_q[1] != "B" || src_q[2] != "A" ||
            s1 !== 4'h2 || s0 !== 4'h3) begin
            n_fail++;
            $display("FAIL tie_order got n=%0d s1=%h s0=%h exp n=3 ABA s1=2 s0=3", src_q.size(), s1, s0);
        end
    endtask

    task automatic test_hold();
        logic [10:0] exp;
        int t_a = -1, t_b = -1;
        a_valid = 1'b1; a_digit = 4'hC;
        for (int i = 0; i < 2 * (H + 1) + 2; i++) begin
            #1; exp = model_out(); n_checks++;
            if ({a_ready, b_ready, busy, s1, s0} !== exp) begin
                n_fail++;
                $display("FAIL hold cyc=%0d got=%h exp=%h", cyc, {a_ready, b_ready, busy, s1, s0}, exp);
            end
            if (a_ready === 1'b1) t_a = cyc;
            if (b_ready === 1'b1) t_b = cyc;
            tick();
            if (m_acc_a) begin b_valid = 1'b1; b_digit = 4'hD; end
        end
        n_checks++;
        if (t_a < 0 || t_b - t_a != H + 1) begin
            n_fail++;
            $display("FAIL hold_spacing got=%0d exp=%0d", t_b - t_a, H + 1);
        end
    endtask

    task automatic test_abort();
        logic [10:0] exp;
        a_valid = 1'b1; a_digit = 4'h6;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin b_valid = 1'b1; b_digit = 4'h8; end
            if (i == 2) rstn = 1'b0;
            #1; exp = model_out(); n_checks++;
            if ({a_ready, b_ready, busy, s1, s0} !== exp) begin
                n_fail++;
                $display("FAIL abort cyc=%0d got=%h exp=%h", cyc, {a_ready, b_ready, busy, s1, s0}, exp);
            end
            tick();
        end
        rstn = 1'b1;
        #1; n_checks++;
        if ({busy, s1, s0} !== 9'h000) begin
            n_fail++;
            $display("FAIL abort_cleared got busy=%b s1=%h s0=%h exp 0 0 0", busy, s1, s0);
        end
        for (int i = 0; i < 3; i++) begin
            #1; exp = model_out(); n_checks++;
            if ({a_ready, b_ready, busy, s1, s0} !== exp) begin
                n_fail++;
                $display("FAIL abort_resume cyc=%0d got=%h exp=%h", cyc, {a_ready, b_ready, busy, s1, s0}, exp);
            end
            tick();
        end
        n_checks++;
        if (s0 !== 4'h8 || s1 !== 4'h0) begin
            n_fail++;
            $display("FAIL abort_pending got s1=%h s0=%h exp s1=0 s0=8", s1, s0);
        end
        repeat (H) tick();
    endtask

    task automatic test_dup();
        a_valid = 1'b1; a_digit = 4'h7;
        repeat (H + 2) tick();
        a_valid = 1'b1; a_digit = 4'h7;
        #1; n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_ready got=%b exp=1", a_ready);
        end
        tick();
        #1; n_checks++;
`ifdef SEG_SCHED_DUP_FILTER_EN
        if ({s1, s0, busy} !== {4'h8, 4'h7, 1'b0}) begin
            n_fail++;
            $display("FAIL dup_filtered got s1=%h s0=%h busy=%b exp s1=8 s0=7 busy=0", s1, s0, busy);
        end
`else
        if ({s1, s0, busy} !== {4'h7, 4'h7, 1'b1}) begin
            n_fail++;
            $display("FAIL dup_shift got s1=%h s0=%h busy=%b exp s1=7 s0=7 busy=1", s1, s0, busy);
        end
`endif
        repeat (H + 1) tick();
    endtask

    task automatic test_random();
        logic [10:0] exp;
        for (int i = 0; i < 400; i++) begin
            rstn = ($urandom_range(0, 59) != 0);
            if (!a_valid && $urandom_range(0, 2) == 0) begin
                a_valid = 1'b1;
                a_digit = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : m_s0;
            end else if (a_valid && $urandom_range(0, 29) == 0) begin
                a_valid = 1'b0;
            end
            if (!b_valid && $urandom_range(0, 2) == 0) begin
                b_valid = 1'b1;
                b_digit = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : m_s0;
            end
            #1; exp = model_out(); n_checks++;
            if ({a_ready, b_ready, busy, s1, s0} !== exp) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {a_ready, b_ready, busy, s1, s0}, exp);
            end
            tick();
        end
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_hold();
        test_abort();
        test_dup();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
